// File: rtl/prog_loader_if.sv
// Loader handshake bundle: start/byte stream in, instruction-memory write port and CPU control out.
// master drives the stream side, slave is the loader.
interface prog_loader_if #(
    parameter int ADDR_W = 8
);
    logic              start;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;
    logic              cpu_rst_n;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output start, in_valid, in_data,
        input  in_ready, mem_we, mem_addr, mem_wdata, cpu_rst_n, busy, done, err
    );

    modport slave (
        input  start, in_valid, in_data,
        output in_ready, mem_we, mem_addr, mem_wdata, cpu_rst_n, busy, done, err
    );
endinterface

// File: rtl/prog_loader.sv
// Framed byte-stream loader: LEN_HI LEN_LO {HI LO}*N CHK -> 16-bit imem writes, CPU held in reset until a good CHK.
// One byte per cycle; write lands the cycle after the LO byte; in_ready is registered and only stalls on in_valid gaps.
module prog_loader #(
    parameter int ADDR_W = 8
) (
    input  logic          CLK,
    input  logic          RST,
    prog_loader_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA_HI,
        DATA_LO,
        CHK
    } state_t;

    localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;

    state_t            state;
    logic [7:0]        xor_acc;
    logic [7:0]        len_hi;
    logic [7:0]        hi_byte;
    logic [ADDR_W:0]   len_words;
    logic [ADDR_W:0]   idx;

    logic              xfer;
    logic [15:0]       len_full;
    logic [ADDR_W:0]   idx_next;

    assign xfer     = bus.in_valid & bus.in_ready;
    assign len_full = {len_hi, bus.in_data};
    assign idx_next = idx + (ADDR_W+1)'(1);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state         <= IDLE;
            xor_acc       <= '0;
            len_hi        <= '0;
            hi_byte       <= '0;
            len_words     <= '0;
            idx           <= '0;
            bus.in_ready  <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.cpu_rst_n <= 1'b1;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.err       <= 1'b0;
        end else begin
            bus.mem_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state         <= LEN_HI;
                        bus.in_ready  <= 1'b1;
                        bus.busy      <= 1'b1;
                        bus.cpu_rst_n <= 1'b0;
                        bus.done      <= 1'b0;
                        bus.err       <= 1'b0;
                        xor_acc       <= '0;
                        idx           <= '0;
                    end
                end
                LEN_HI: begin
                    if (xfer) begin
                        len_hi  <= bus.in_data;
                        xor_acc <= xor_acc ^ bus.in_data;
                        state   <= LEN_LO;
                    end
                end
                LEN_LO: begin
                    if (xfer) begin
                        xor_acc   <= xor_acc ^ bus.in_data;
                        len_words <= len_full[ADDR_W:0];
                        // N == 2**ADDR_W is legal; only strictly larger images overflow memory
                        if ({1'b0, len_full} > MAX_WORDS) begin
                            bus.err      <= 1'b1;
                            bus.in_ready <= 1'b0;
                            bus.busy     <= 1'b0;
                            state        <= IDLE;
                        end else if (len_full == 16'd0) begin
                            state <= CHK;
                        end else begin
                            state <= DATA_HI;
                        end
                    end
                end
                DATA_HI: begin
                    if (xfer) begin
                        hi_byte <= bus.in_data;
                        xor_acc <= xor_acc ^ bus.in_data;
                        state   <= DATA_LO;
                    end
                end
                DATA_LO: begin
                    if (xfer) begin
                        bus.mem_we    <= 1'b1;
                        bus.mem_addr  <= idx[ADDR_W-1:0];
                        bus.mem_wdata <= {hi_byte, bus.in_data};
                        xor_acc       <= xor_acc ^ bus.in_data;
                        idx           <= idx_next;
                        state         <= (idx_next == len_words) ? CHK : DATA_HI;
                    end
                end
                CHK: begin
                    if (xfer) begin
                        if (bus.in_data == xor_acc) begin
                            bus.done      <= 1'b1;
                            bus.cpu_rst_n <= 1'b1;
                        end else begin
                            bus.err <= 1'b1;
                        end
                        bus.in_ready <= 1'b0;
                        bus.busy     <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: begin
                    state        <= IDLE;
                    bus.in_ready <= 1'b0;
                    bus.busy     <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/prog_loader.md
# prog_loader

Byte-stream program loader for the 16-bit single-cycle CPU. It accepts a framed byte stream over a valid/ready handshake and assembles big-endian 16-bit instruction words. Each word is written into instruction memory through a single-cycle write port. The CPU is held in reset for the whole load and released only after a checksum-verified image. This is the writer side of the instruction memory, which the CPU core only reads.

## Interface
Parameters:
- ADDR_W, 8, instruction memory address width; capacity 2**ADDR_W words

Ports:
- CLK  in  1  system clock, rising edge
- RST  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins a load when in IDLE, ignored otherwise
- in_valid  in  1  byte available on in_data
- in_data  in  8  stream byte
- in_ready  out  1  loader can accept a byte
- mem_we  out  1  instruction memory write strobe, one cycle per word
- mem_addr  out  ADDR_W  write word address
- mem_wdata  out  16  write data
- cpu_rst_n  out  1  active-low reset to the CPU core
- busy  out  1  load in progress
- done  out  1  sticky: last load succeeded
- err  out  1  sticky: last load failed (length or checksum)

## Operation
- Frame format: LEN_HI, LEN_LO, then N words each sent as HI byte then LO byte, then CHK.
  - N = {LEN_HI, LEN_LO}.
  - CHK equals the XOR of all 2+2N preceding bytes.
- A byte transfers on a rising edge with in_valid=1 and in_ready=1. in_ready is a registered output, equal to 1 exactly in states LEN_HI, LEN_LO, DATA_HI, DATA_LO and CHK.
- FSM states: IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHK.
  - IDLE: on start go to LEN_HI. Clear done, err, the running XOR and the word index.
  - LEN_HI: on a transfer go to LEN_LO.
  - LEN_LO: on a transfer, if N > 2**ADDR_W, set err and go to IDLE. Else if N=0 go to CHK. Else go to DATA_HI.
  - DATA_HI: on a transfer latch the high byte and go to DATA_LO.
  - DATA_LO: on a transfer issue the write, increment the word index, and go to CHK if index+1==N, else to DATA_HI.
  - CHK: on a transfer compare the byte with the running XOR. On a match set done, else set err. Then go to IDLE.
- The running XOR covers every accepted byte except CHK. It is 8 bits wide.
- The word index counter is ADDR_W+1 bits so it does not wrap at N = 2**ADDR_W. mem_addr = index[ADDR_W-1:0].
- Words are written as they arrive. A failed checksum does not undo writes already made.
- cpu_rst_n:
  - Reset value 1, so a preloaded memory runs.
  - Driven to 0 the cycle after start is accepted.
  - Returns to 1 only on a successful CHK.
  - On err it stays 0 until the next successful load.
- busy = (state != IDLE).
- A start while busy is ignored. start and a byte transfer in the same cycle in IDLE: the byte is not accepted.

## Timing
- Reset values: state IDLE, in_ready 0, mem_we 0, mem_addr 0, mem_wdata 0, cpu_rst_n 1, busy 0, done 0, err 0.
- Reset asserted mid-load: all outputs return to their reset values immediately. Memory keeps any partial contents. No write is issued after reset assertion.
- start at edge k: at k+1, busy=1, in_ready=1, cpu_rst_n=0.
- DATA_LO transfer at edge k: at k+1, mem_we=1 for exactly one cycle, with mem_addr and mem_wdata = {HI, LO} valid that same cycle.
- CHK transfer at edge k:
  - at k+1: state IDLE, in_ready 0, busy 0, done or err set.
  - on success, cpu_rst_n=1 at k+1.
- Length error at the LEN_LO edge k: err=1 and in_ready=0 at k+1. No write occurs.
- Back-to-back bytes at one per cycle are sustained. Gaps in in_valid only stall the FSM.
- Minimum load time for N words: 1 + 2 + 2N + 1 cycles from start to done.

## Test plan
- Nominal, ADDR_W=8: start, then bytes 00 02 60 00 70 01 13 -> writes addr0=0x6000 and addr1=0x7001, one mem_we each; done=1, err=0, cpu_rst_n 0->1 on the cycle after CHK.
- Bad checksum: same stream with CHK=14 -> both writes occur, err=1, done=0, cpu_rst_n stays 0.
- Empty image: bytes 00 00 00 -> no mem_we, done=1, cpu_rst_n returns to 1.
- Oversize: bytes 01 01 (N=257) -> err=1 after the second byte, in_ready=0, no mem_we. Subsequent bytes are ignored.
- Backpressure and start-while-busy: nominal stream with random in_valid gaps and extra start pulses mid-load -> identical writes and result to the nominal case.
- Reset mid-load: assert RST after the bytes 00 02 60 -> all outputs at reset values, no write issued. A following nominal load succeeds.
